// File: rtl/canny_pkg.sv
// Shared definitions for the canny pipeline sequencer: FSM states, slot phase
// layout and the default frame geometry.
package canny_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } canny_state_e;

  localparam int ADDR_W = 20;

  // Phase layout inside one word slot; hold and multiply trail the shifter.
  localparam int PH_POP         = 0;
  localparam int PH_SHIFT_FIRST = 1;
  localparam int PH_SHIFT_LAST  = 4;
  localparam int PH_HOLD_OFS    = 1;
  localparam int PH_MULT_OFS    = 2;

  localparam int DEF_WORDS_PER_ROW  = 64;
  localparam int DEF_ROWS           = 512;
  localparam int DEF_SLOT_LEN       = 8;
  localparam int DEF_PRIME_WORDS    = 128;
  localparam int DEF_DRAIN_SLOTS    = 128;
  localparam int DEF_NEXT_THRESHOLD = 26214;

endpackage

// File: rtl/canny_slot_decoder.sv
// Combinational slot decoder: phase plus gating flags to the five datapath
// enables. The parent registers these outputs.
module canny_slot_decoder
  import canny_pkg::*;
#(
  parameter int SLOT_LEN = DEF_SLOT_LEN,
  parameter int PHASE_W  = 3
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic               active,
  input  logic               popAllow,
  input  logic               resultAllow,
  output logic               popEn,
  output logic               shiftEn,
  output logic               holdEn,
  output logic               multEn,
  output logic               outEn
);

  logic [31:0] ph;

  always_comb begin
    ph      = 32'(phase);
    popEn   = active && popAllow && (ph == PH_POP);
    shiftEn = active && (ph >= PH_SHIFT_FIRST) && (ph <= PH_SHIFT_LAST);
    holdEn  = active && (ph >= PH_SHIFT_FIRST + PH_HOLD_OFS)
                     && (ph <= PH_SHIFT_LAST + PH_HOLD_OFS);
    multEn  = active && resultAllow && (ph >= PH_SHIFT_FIRST + PH_MULT_OFS)
                     && (ph <= PH_SHIFT_LAST + PH_MULT_OFS);
    outEn   = active && resultAllow && (ph == SLOT_LEN - 1);
  end

endmodule

// File: rtl/canny_pipeline_sequencer.sv
// Per-word slot sequencer for the canny datapath: walks a frame of SRAM words,
// primes, drains and signals frame completion. All outputs are registered.
module canny_pipeline_sequencer
  import canny_pkg::*;
#(
  parameter int               WORDS_PER_ROW  = DEF_WORDS_PER_ROW,
  parameter int               ROWS           = DEF_ROWS,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int               SLOT_LEN       = DEF_SLOT_LEN,
  parameter int               PRIME_WORDS    = DEF_PRIME_WORDS,
  parameter int               DRAIN_SLOTS    = DEF_DRAIN_SLOTS,
  parameter int               NEXT_THRESHOLD = DEF_NEXT_THRESHOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startEn,
  input  logic              stall,
  output logic [ADDR_W-1:0] read_addr,
  output logic              popBufferEn,
  output logic              cannyShiftEn,
  output logic              HoldEn,
  output logic              startMultiplierEn,
  output logic              outEn,
  output logic              getNext,
  output logic              busy,
  output logic              frameDone
);

  // Handshake: startEn is a level request taken only in IDLE (no queuing);
  // getNext is a one-cycle pulse with no acknowledge; stall freezes progress.

  localparam int PHASE_W     = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int TOTAL_WORDS = WORDS_PER_ROW * ROWS;

  canny_state_e        state, nextState;
  logic [PHASE_W-1:0]  phase;
  logic [ADDR_W-1:0]   wordIdx;
  logic [ADDR_W-1:0]   drainCnt;
  logic                active, slotEnd, resultAllow;
  logic                popD, shiftD, holdD, multD, outD;

  always_comb begin
    active      = ((state == RUN) || (state == DRAIN)) && !stall;
    slotEnd     = active && (32'(phase) == SLOT_LEN - 1);
    resultAllow = (state == DRAIN) || (32'(wordIdx) >= PRIME_WORDS);
    nextState   = state;
    unique case (state)
      IDLE:    if (startEn) nextState = RUN;
      RUN:     if (slotEnd && (32'(wordIdx) == TOTAL_WORDS - 1)) nextState = DRAIN;
      DRAIN:   if (slotEnd && (32'(drainCnt) == DRAIN_SLOTS - 1)) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  canny_slot_decoder #(
    .SLOT_LEN (SLOT_LEN),
    .PHASE_W  (PHASE_W)
  ) u_decoder (
    .phase       (phase),
    .active      (active),
    .popAllow    (state == RUN),
    .resultAllow (resultAllow),
    .popEn       (popD),
    .shiftEn     (shiftD),
    .holdEn      (holdD),
    .multEn      (multD),
    .outEn       (outD)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      phase             <= '0;
      wordIdx           <= '0;
      drainCnt          <= '0;
      read_addr         <= BASE_ADDR;
      popBufferEn       <= 1'b0;
      cannyShiftEn      <= 1'b0;
      HoldEn            <= 1'b0;
      startMultiplierEn <= 1'b0;
      outEn             <= 1'b0;
      getNext           <= 1'b0;
      busy              <= 1'b0;
      frameDone         <= 1'b0;
    end else begin
      state             <= nextState;
      popBufferEn       <= popD;
      cannyShiftEn      <= shiftD;
      HoldEn            <= holdD;
      startMultiplierEn <= multD;
      outEn             <= outD;
      busy              <= (nextState != IDLE);
      frameDone         <= (nextState == DONE);
      getNext           <= 1'b0;
      if ((state == IDLE) && startEn) begin
        phase     <= '0;
        wordIdx   <= '0;
        drainCnt  <= '0;
        read_addr <= BASE_ADDR;
        getNext   <= (NEXT_THRESHOLD == 0) && (TOTAL_WORDS > 0);
      end else if (active) begin
        phase <= slotEnd ? '0 : phase + 1'b1;
        // The refill request fires on the edge that moves wordIdx onto the threshold.
        if (slotEnd && (state == RUN)) begin
          wordIdx   <= wordIdx + 1'b1;
          read_addr <= read_addr + 1'b1;
          getNext   <= (32'(wordIdx) + 1 == NEXT_THRESHOLD) && (NEXT_THRESHOLD < TOTAL_WORDS);
        end
        if (slotEnd && (state == DRAIN)) begin
          drainCnt <= drainCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_canny_pipeline_sequencer.sv
// Bench for canny_pipeline_sequencer: small-geometry frames with random stalls
// and ignored start pokes, checked against a progress-count reference model.
module tb_canny_pipeline_sequencer;

  localparam int          WPR    = 4;
  localparam int          NROWS  = 4;
  localparam int          SL     = 8;
  localparam int          PRIME  = 8;
  localparam int          NDRAIN = 2;
  localparam int          THR    = 12;
  localparam int          NW     = WPR * NROWS;
  localparam logic [19:0] BASE   = 20'h00000;
  localparam logic [19:0] WBASE  = 20'hFFFFE;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        startEn = 1'b0;
  logic        stall = 1'b0;
  logic [19:0] read_addr;
  logic        popBufferEn, cannyShiftEn, HoldEn, startMultiplierEn, outEn;
  logic        getNext, busy, frameDone;

  logic        startW = 1'b0;
  logic        stallW = 1'b0;
  logic [19:0] readAddrW;
  logic        popW, shiftW, holdW, multW, outW, getNextW, busyW, frameDoneW;

  canny_pipeline_sequencer #(
    .WORDS_PER_ROW (WPR), .ROWS (NROWS), .BASE_ADDR (BASE), .SLOT_LEN (SL),
    .PRIME_WORDS (PRIME), .DRAIN_SLOTS (NDRAIN), .NEXT_THRESHOLD (THR)
  ) dut (
    .clk (clk), .reset (reset), .startEn (startEn), .stall (stall),
    .read_addr (read_addr), .popBufferEn (popBufferEn), .cannyShiftEn (cannyShiftEn),
    .HoldEn (HoldEn), .startMultiplierEn (startMultiplierEn), .outEn (outEn),
    .getNext (getNext), .busy (busy), .frameDone (frameDone)
  );

  canny_pipeline_sequencer #(
    .WORDS_PER_ROW (4), .ROWS (1), .BASE_ADDR (WBASE), .SLOT_LEN (SL),
    .PRIME_WORDS (PRIME), .DRAIN_SLOTS (1), .NEXT_THRESHOLD (THR)
  ) dut_wrap (
    .clk (clk), .reset (reset), .startEn (startW), .stall (stallW),
    .read_addr (readAddrW), .popBufferEn (popW), .cannyShiftEn (shiftW),
    .HoldEn (holdW), .startMultiplierEn (multW), .outEn (outW),
    .getNext (getNextW), .busy (busyW), .frameDone (frameDoneW)
  );

  // scoreboard: {read_addr, pop, shift, hold, mult, out, getNext, busy, frameDone}
  logic [27:0] exp_q[$];
  logic [27:0] obs_q[$];
  bit          stall_plan[$];
  bit          start_plan[$];
  int          vectors = 0;
  int          miscompares = 0;
  int cnt_pop, cnt_shift, cnt_hold, cnt_mult, cnt_out, cnt_gn, cnt_fd;
  int gn_cycle, fd_cycle, first_out;

  function automatic logic [27:0] sample();
    return {read_addr, popBufferEn, cannyShiftEn, HoldEn, startMultiplierEn,
            outEn, getNext, busy, frameDone};
  endfunction

  // Reference model: the frame is (NW+NDRAIN)*SL units of work; each unstalled
  // busy cycle consumes one unit, whose enables appear one cycle later.
  task automatic build_model(input int stallPct, input int fixStart, input int fixLen,
                             input int pokePct);
    int total, q, prevU, tail, k, s, p, w;
    bit prevAct, st, inRun, resOk, poke;
    logic [7:0]  f;
    logic [19:0] addr;
    exp_q.delete(); stall_plan.delete(); start_plan.delete();
    total = (NW + NDRAIN) * SL;
    q = 0; prevU = 0; tail = 0; k = 0; prevAct = 0;
    while (tail < 3) begin
      f = '0;
      if (prevAct) begin
        s = prevU / SL; p = prevU % SL;
        inRun = (s < NW);
        resOk = !inRun || (s >= PRIME);
        f[7] = inRun && (p == 0);
        f[6] = (p >= 1) && (p <= 4);
        f[5] = (p >= 2) && (p <= 5);
        f[4] = resOk && (p >= 3) && (p <= 6);
        f[3] = resOk && (p == SL - 1);
        f[2] = inRun && (p == SL - 1) && (s + 1 == THR) && (THR < NW);
      end
      f[1] = (q <= total);
      f[0] = (q == total);
      w = (q / SL < NW) ? q / SL : NW;
      addr = BASE + 20'(w);
      exp_q.push_back({addr, f});
      st = ((k >= fixStart) && (k < fixStart + fixLen)) || ($urandom_range(0, 99) < stallPct);
      stall_plan.push_back(st);
      poke = 1'b0;
      if (q == total) poke = (pokePct > 0);
      else if (q < total) poke = ($urandom_range(0, 99) < pokePct);
      start_plan.push_back(poke);
      if ((q < total) && !st) begin
        prevAct = 1'b1; prevU = q; q++;
      end else begin
        prevAct = 1'b0;
        if (q == total) q = total + 1;
        else if (q > total) tail++;
      end
      k++;
    end
  endtask

  // driver: start in the current (idle) cycle, then replay the stall/start plans
  task automatic drive_frame();
    int n;
    logic [27:0] o;
    n = exp_q.size();
    obs_q.delete();
    cnt_pop = 0; cnt_shift = 0; cnt_hold = 0; cnt_mult = 0; cnt_out = 0;
    cnt_gn = 0; cnt_fd = 0; gn_cycle = -1; fd_cycle = -1; first_out = -1;
    startEn = 1'b1;
    stall = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      o = sample();
      obs_q.push_back(o);
      if (o[7]) cnt_pop++;
      if (o[6]) cnt_shift++;
      if (o[5]) cnt_hold++;
      if (o[4]) cnt_mult++;
      if (o[3]) begin cnt_out++; if (first_out < 0) first_out = k; end
      if (o[2]) begin cnt_gn++; if (gn_cycle < 0) gn_cycle = k; end
      if (o[0]) begin cnt_fd++; if (fd_cycle < 0) fd_cycle = k; end
      startEn = start_plan[k];
      stall = stall_plan[k];
    end
    startEn = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; startEn = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (sample() !== {BASE, 8'h00}) begin
      miscompares++; $display("FAIL reset_main: observed %h expected %h", sample(), {BASE, 8'h00});
    end
    vectors++;
    if ({readAddrW, popW, shiftW, holdW, multW, outW, getNextW, busyW, frameDoneW} !== {WBASE, 8'h00}) begin
      miscompares++; $display("FAIL reset_wrap: observed addr %h busy %b expected addr %h all low", readAddrW, busyW, WBASE);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      stall = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      vectors++;
      if (sample() !== {BASE, 8'h00}) begin
        miscompares++; $display("FAIL idle_after_reset cycle %0d: observed %h expected %h", k, sample(), {BASE, 8'h00});
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_frame_basic();
    build_model(0, -1, 0, 0);
    drive_frame();
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL basic_trace cycle %0d: observed %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    vectors++; if (cnt_pop !== NW) begin miscompares++; $display("FAIL basic_pop_count: observed %0d expected %0d", cnt_pop, NW); end
    vectors++; if (cnt_shift !== 4 * (NW + NDRAIN)) begin miscompares++; $display("FAIL basic_shift_count: observed %0d expected %0d", cnt_shift, 4 * (NW + NDRAIN)); end
    vectors++; if (cnt_hold !== 4 * (NW + NDRAIN)) begin miscompares++; $display("FAIL basic_hold_count: observed %0d expected %0d", cnt_hold, 4 * (NW + NDRAIN)); end
    vectors++; if (cnt_mult !== 4 * (NW - PRIME + NDRAIN)) begin miscompares++; $display("FAIL basic_mult_count: observed %0d expected %0d", cnt_mult, 4 * (NW - PRIME + NDRAIN)); end
    vectors++; if (cnt_out !== NW - PRIME + NDRAIN) begin miscompares++; $display("FAIL basic_out_count: observed %0d expected %0d", cnt_out, NW - PRIME + NDRAIN); end
    vectors++; if (first_out !== PRIME * SL + SL) begin miscompares++; $display("FAIL basic_first_out: observed cycle %0d expected %0d", first_out, PRIME * SL + SL); end
    vectors++; if (cnt_gn !== 1 || gn_cycle !== THR * SL) begin miscompares++; $display("FAIL basic_getnext: observed count %0d cycle %0d expected 1 at %0d", cnt_gn, gn_cycle, THR * SL); end
    vectors++; if (cnt_fd !== 1 || fd_cycle !== 144) begin miscompares++; $display("FAIL basic_framedone: observed count %0d cycle %0d expected 1 at 144", cnt_fd, fd_cycle); end
  endtask

  task automatic test_stall();
    // phase 3 of slot 9 is held in cycle 9*SL+3
    build_model(0, 9 * SL + 3, 5, 0);
    drive_frame();
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL stall_trace cycle %0d: observed %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    for (int k = 9 * SL + 4; k < 9 * SL + 8; k++) begin
      vectors++;
      if (obs_q[k][7:3] !== 5'b0) begin
        miscompares++; $display("FAIL stall_enables_low cycle %0d: observed %b expected 00000", k, obs_q[k][7:3]);
      end
    end
    vectors++; if (cnt_shift !== 4 * (NW + NDRAIN) || cnt_mult !== 4 * (NW - PRIME + NDRAIN) || cnt_out !== NW - PRIME + NDRAIN) begin miscompares++; $display("FAIL stall_totals: observed shift %0d mult %0d out %0d expected 72 40 10", cnt_shift, cnt_mult, cnt_out); end
    vectors++; if (fd_cycle !== 149) begin miscompares++; $display("FAIL stall_framedone: observed cycle %0d expected 149", fd_cycle); end
  endtask

  task automatic test_start_ignored();
    build_model(0, -1, 0, 15);
    drive_frame();
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL ignore_trace cycle %0d: observed %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    vectors++; if (cnt_fd !== 1 || fd_cycle !== 144) begin miscompares++; $display("FAIL ignore_framedone: observed count %0d cycle %0d expected 1 at 144", cnt_fd, fd_cycle); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      build_model(20, -1, 0, 10);
      drive_frame();
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (obs_q[k] !== exp_q[k]) begin
          miscompares++; $display("FAIL b2b_trace frame %0d cycle %0d: observed %h expected %h", f, k, obs_q[k], exp_q[k]);
        end
      end
      vectors++; if (cnt_pop !== NW || cnt_hold !== 4 * (NW + NDRAIN) || cnt_out !== NW - PRIME + NDRAIN || cnt_gn !== 1) begin miscompares++; $display("FAIL b2b_totals frame %0d: observed pop %0d hold %0d out %0d gn %0d expected 16 72 10 1", f, cnt_pop, cnt_hold, cnt_out, cnt_gn); end
    end
  endtask

  task automatic test_async_reset();
    startEn = 1'b1; stall = 1'b0;
    @(posedge clk); #1;
    startEn = 1'b0;
    repeat (6 * SL + 3) @(posedge clk);
    #1;
    vectors++;
    if (cannyShiftEn !== 1'b1 || read_addr !== BASE + 20'd6 || busy !== 1'b1) begin
      miscompares++; $display("FAIL areset_precondition: observed shift %b addr %h busy %b expected 1 %h 1", cannyShiftEn, read_addr, busy, BASE + 20'd6);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (sample() !== {BASE, 8'h00}) begin
      miscompares++; $display("FAIL areset_immediate: observed %h expected %h", sample(), {BASE, 8'h00});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (sample() !== {BASE, 8'h00}) begin
        miscompares++; $display("FAIL areset_idle cycle %0d: observed %h expected %h", k, sample(), {BASE, 8'h00});
      end
    end
    build_model(0, -1, 0, 0);
    drive_frame();
    for (int k = 0; k < exp_q.size(); k++) begin
      vectors++;
      if (obs_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL areset_clean_trace cycle %0d: observed %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [19:0] wexp[$];
    logic [19:0] e;
    int fdw, gnw;
    wexp = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    fdw = -1; gnw = 0;
    startW = 1'b1;
    @(posedge clk); #1;
    startW = 1'b0;
    for (int k = 0; k < 44; k++) begin
      if (popW) begin
        vectors++;
        if (wexp.size() == 0) begin
          miscompares++; $display("FAIL wrap_extra_pop cycle %0d: observed addr %h expected no pop", k, readAddrW);
        end else begin
          e = wexp.pop_front();
          if (readAddrW !== e) begin
            miscompares++; $display("FAIL wrap_addr cycle %0d: observed %h expected %h", k, readAddrW, e);
          end
        end
      end
      if (getNextW) gnw++;
      if (frameDoneW && fdw < 0) fdw = k;
      @(posedge clk); #1;
    end
    vectors++; if (wexp.size() !== 0) begin miscompares++; $display("FAIL wrap_missing_pops: observed %0d left expected 0", wexp.size()); end
    vectors++; if (gnw !== 0) begin miscompares++; $display("FAIL wrap_getnext: observed %0d pulses expected 0", gnw); end
    vectors++; if (fdw !== 5 * SL) begin miscompares++; $display("FAIL wrap_framedone: observed cycle %0d expected %0d", fdw, 5 * SL); end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_addr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
